// File: rtl/vga_blob_tracker_if.sv
// Pixel-stream input and per-channel result record of the blob tracker.
// Tracker side uses slave, pixel source / consumer side uses master.
interface vga_blob_tracker_if #(
    parameter int VGA_WIDTH  = 320,
    parameter int VGA_HEIGHT = 240,
    parameter int CH         = 2
);
    localparam int XW  = $clog2(VGA_WIDTH);
    localparam int YW  = $clog2(VGA_HEIGHT);
    localparam int CW  = $clog2(VGA_WIDTH * VGA_HEIGHT + 1);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           frame_start;
    logic           pix_valid;
    logic [CH-1:0]  thres;
    logic           res_valid;
    logic [CHW-1:0] res_ch;
    logic           res_found;
    logic [CW-1:0]  res_cnt;
    logic [XW-1:0]  res_x;
    logic [YW-1:0]  res_y;
    logic [XW-1:0]  res_xmin;
    logic [XW-1:0]  res_xmax;
    logic [YW-1:0]  res_ymin;
    logic [YW-1:0]  res_ymax;
    logic           busy;
    logic           frame_drop;

    modport master (
        output frame_start, pix_valid, thres,
        input  res_valid, res_ch, res_found, res_cnt,
        input  res_x, res_y, res_xmin, res_xmax, res_ymin, res_ymax,
        input  busy, frame_drop
    );

    modport slave (
        input  frame_start, pix_valid, thres,
        output res_valid, res_ch, res_found, res_cnt,
        output res_x, res_y, res_xmin, res_xmax, res_ymin, res_ymax,
        output busy, frame_drop
    );
endinterface

// File: rtl/vga_blob_tracker.sv
// Per-channel blob statistics over a thresholded pixel stream, with a
// shared restoring divider producing rounded centroids at end of frame.
module vga_blob_tracker #(
    parameter int VGA_WIDTH  = 320,
    parameter int VGA_HEIGHT = 240,
    parameter int CH         = 2,
    parameter int MIN_CNT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    vga_blob_tracker_if.slave  bus
);
    localparam int XW  = $clog2(VGA_WIDTH);
    localparam int YW  = $clog2(VGA_HEIGHT);
    localparam int CW  = $clog2(VGA_WIDTH * VGA_HEIGHT + 1);
    localparam int SW  = $clog2(VGA_WIDTH * VGA_HEIGHT * (VGA_WIDTH - 1) + 1);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW  = $clog2(SW + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_EMIT} state_t;

    state_t r_state, w_state_n;

    logic [XW-1:0] r_x, w_xe;
    logic [YW-1:0] r_y, w_ye;
    logic          w_eol, w_eof;

    logic [CW-1:0] r_cnt [CH];
    logic [SW-1:0] r_sx  [CH];
    logic [SW-1:0] r_sy  [CH];
    logic [XW-1:0] r_xmin[CH];
    logic [XW-1:0] r_xmax[CH];
    logic [YW-1:0] r_ymin[CH];
    logic [YW-1:0] r_ymax[CH];

    logic [CW-1:0] r_sh_cnt [CH];
    logic [SW-1:0] r_sh_sx  [CH];
    logic [SW-1:0] r_sh_sy  [CH];
    logic [XW-1:0] r_sh_xmin[CH];
    logic [XW-1:0] r_sh_xmax[CH];
    logic [YW-1:0] r_sh_ymin[CH];
    logic [YW-1:0] r_sh_ymax[CH];

    logic [CH-1:0] w_hit;
    logic [CW-1:0] w_cnt_n  [CH];
    logic [SW-1:0] w_sx_n   [CH];
    logic [SW-1:0] w_sy_n   [CH];
    logic [XW-1:0] w_bxmin  [CH];
    logic [XW-1:0] w_bxmax  [CH];
    logic [YW-1:0] w_bymin  [CH];
    logic [YW-1:0] w_bymax  [CH];
    logic [XW-1:0] w_xmin_n [CH];
    logic [XW-1:0] w_xmax_n [CH];
    logic [YW-1:0] w_ymin_n [CH];
    logic [YW-1:0] w_ymax_n [CH];

    logic [CHW-1:0] r_chn;
    logic [BW-1:0]  r_bit;
    logic           w_last;
    logic [SW-1:0]  r_q, w_q_in, w_q_n, w_dvd;
    logic [CW-1:0]  r_rem, w_rem_in, w_rem_n, w_dvs;
    logic [CW:0]    w_rem_sh, w_diff;
    logic           w_ge, w_found;
    logic [XW-1:0]  r_qx;

    logic           r_drop;
    logic [CHW-1:0] r_res_ch;
    logic           r_res_found;
    logic [CW-1:0]  r_res_cnt;
    logic [XW-1:0]  r_res_x, r_res_xmin, r_res_xmax;
    logic [YW-1:0]  r_res_y, r_res_ymin, r_res_ymax;

    // frame_start with a coincident pixel places that pixel at (0,0)
    assign w_xe  = bus.frame_start ? '0 : r_x;
    assign w_ye  = bus.frame_start ? '0 : r_y;
    assign w_eol = bus.pix_valid && (w_xe == XW'(VGA_WIDTH - 1));
    assign w_eof = w_eol && (w_ye == YW'(VGA_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (bus.pix_valid) begin
            if (w_eol) begin
                r_x <= '0;
                r_y <= w_eof ? '0 : w_ye + 1'b1;
            end else begin
                r_x <= w_xe + 1'b1;
                r_y <= w_ye;
            end
        end else if (bus.frame_start) begin
            r_x <= '0;
            r_y <= '0;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int c = 0; c < CH; c++) begin
            w_hit[c]    = bus.pix_valid & bus.thres[c];
            w_cnt_n[c]  = (bus.frame_start ? '0 : r_cnt[c]) + CW'(w_hit[c]);
            w_sx_n[c]   = (bus.frame_start ? '0 : r_sx[c])
                        + (w_hit[c] ? SW'(w_xe) : '0);
            w_sy_n[c]   = (bus.frame_start ? '0 : r_sy[c])
                        + (w_hit[c] ? SW'(w_ye) : '0);
            w_bxmin[c]  = bus.frame_start ? '1 : r_xmin[c];
            w_bxmax[c]  = bus.frame_start ? '0 : r_xmax[c];
            w_bymin[c]  = bus.frame_start ? '1 : r_ymin[c];
            w_bymax[c]  = bus.frame_start ? '0 : r_ymax[c];
            w_xmin_n[c] = (w_hit[c] && w_xe < w_bxmin[c]) ? w_xe : w_bxmin[c];
            w_xmax_n[c] = (w_hit[c] && w_xe > w_bxmax[c]) ? w_xe : w_bxmax[c];
            w_ymin_n[c] = (w_hit[c] && w_ye < w_bymin[c]) ? w_ye : w_bymin[c];
            w_ymax_n[c] = (w_hit[c] && w_ye > w_bymax[c]) ? w_ye : w_bymax[c];
        end
    end

    // Live accumulators restart at frame end; the finished frame goes to
    // the shadows only when the divider is free to take it.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst || w_eof) begin
                r_cnt[c]  <= '0;
                r_sx[c]   <= '0;
                r_sy[c]   <= '0;
                r_xmin[c] <= '1;
                r_xmax[c] <= '0;
                r_ymin[c] <= '1;
                r_ymax[c] <= '0;
            end else if (bus.frame_start || bus.pix_valid) begin
                r_cnt[c]  <= w_cnt_n[c];
                r_sx[c]   <= w_sx_n[c];
                r_sy[c]   <= w_sy_n[c];
                r_xmin[c] <= w_xmin_n[c];
                r_xmax[c] <= w_xmax_n[c];
                r_ymin[c] <= w_ymin_n[c];
                r_ymax[c] <= w_ymax_n[c];
            end
            if (rst) begin
                r_sh_cnt[c]  <= '0;
                r_sh_sx[c]   <= '0;
                r_sh_sy[c]   <= '0;
                r_sh_xmin[c] <= '1;
                r_sh_xmax[c] <= '0;
                r_sh_ymin[c] <= '1;
                r_sh_ymax[c] <= '0;
            end else if (w_eof && r_state == S_IDLE) begin
                r_sh_cnt[c]  <= w_cnt_n[c];
                r_sh_sx[c]   <= w_sx_n[c];
                r_sh_sy[c]   <= w_sy_n[c];
                r_sh_xmin[c] <= w_xmin_n[c];
                r_sh_xmax[c] <= w_xmax_n[c];
                r_sh_ymin[c] <= w_ymin_n[c];
                r_sh_ymax[c] <= w_ymax_n[c];
            end
        end
    end

    // Restoring divider; bit counter 0 marks the load step of each phase
    assign w_last   = (r_bit == BW'(SW - 1));
    assign w_dvs    = r_sh_cnt[r_chn];
    assign w_dvd    = (r_state == S_DIV_Y ? r_sh_sy[r_chn] : r_sh_sx[r_chn])
                    + SW'(w_dvs >> 1);
    assign w_q_in   = (r_bit == '0) ? w_dvd : r_q;
    assign w_rem_in = (r_bit == '0) ? '0 : r_rem;
    assign w_rem_sh = {w_rem_in, w_q_in[SW-1]};
    assign w_diff   = w_rem_sh - {1'b0, w_dvs};
    assign w_ge     = ~w_diff[CW];
    assign w_rem_n  = w_ge ? w_diff[CW-1:0] : w_rem_sh[CW-1:0];
    assign w_q_n    = {w_q_in[SW-2:0], w_ge};
    assign w_found  = (w_dvs != '0) && (int'(w_dvs) >= MIN_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:  if (w_eof) w_state_n = S_DIV_X;
            S_DIV_X: if (w_last) w_state_n = S_DIV_Y;
            S_DIV_Y: if (w_last) w_state_n = S_EMIT;
            S_EMIT:  w_state_n = (r_chn == CHW'(CH - 1)) ? S_IDLE : S_DIV_X;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chn <= '0;
            r_bit <= '0;
            r_q   <= '0;
            r_rem <= '0;
            r_qx  <= '0;
        end else begin
            if (r_state == S_DIV_X || r_state == S_DIV_Y) begin
                r_q   <= w_q_n;
                r_rem <= w_rem_n;
                r_bit <= w_last ? '0 : r_bit + 1'b1;
                if (r_state == S_DIV_X && w_last) r_qx <= w_q_n[XW-1:0];
            end
            if (r_state == S_EMIT) begin
                r_chn <= (r_chn == CHW'(CH - 1)) ? '0 : r_chn + 1'b1;
            end
        end
    end

    // Record is latched on the final divide step so it is stable in EMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop      <= 1'b0;
            r_res_ch    <= '0;
            r_res_found <= 1'b0;
            r_res_cnt   <= '0;
            r_res_x     <= '1;
            r_res_y     <= '1;
            r_res_xmin  <= '0;
            r_res_xmax  <= '0;
            r_res_ymin  <= '0;
            r_res_ymax  <= '0;
        end else begin
            r_drop <= w_eof && (r_state != S_IDLE);
            if (r_state == S_DIV_Y && w_last) begin
                r_res_ch    <= r_chn;
                r_res_found <= w_found;
                r_res_cnt   <= w_dvs;
                r_res_x     <= w_found ? r_qx : '1;
                r_res_y     <= w_found ? w_q_n[YW-1:0] : '1;
                r_res_xmin  <= r_sh_xmin[r_chn];
                r_res_xmax  <= r_sh_xmax[r_chn];
                r_res_ymin  <= r_sh_ymin[r_chn];
                r_res_ymax  <= r_sh_ymax[r_chn];
            end
        end
    end

    assign bus.res_valid  = (r_state == S_EMIT);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_drop = r_drop;
    assign bus.res_ch     = r_res_ch;
    assign bus.res_found  = r_res_found;
    assign bus.res_cnt    = r_res_cnt;
    assign bus.res_x      = r_res_x;
    assign bus.res_y      = r_res_y;
    assign bus.res_xmin   = r_res_xmin;
    assign bus.res_xmax   = r_res_xmax;
    assign bus.res_ymin   = r_res_ymin;
    assign bus.res_ymax   = r_res_ymax;
endmodule

// File: tb/tb_vga_blob_tracker.sv
// Bench for vga_blob_tracker: a 32x16 two-channel instance for the main
// function and a 4x2 instance for frame overrun.
module tb_vga_blob_tracker;
    localparam int AW = 32, AH = 16, AMIN = 4;
    localparam int A_XW = $clog2(AW), A_YW = $clog2(AH);
    localparam int A_SW = $clog2(AW * AH * (AW - 1) + 1);
    localparam int A_LAT = 2 * A_SW + 1;
    localparam int BW = 4, BH = 2, BMIN = 1;
    localparam int B_XW = $clog2(BW), B_YW = $clog2(BH);

    typedef struct {
        int ch, found, cnt, x, y, xmin, xmax, ymin, ymax;
        longint cyc;
    } rec_t;

    typedef struct {
        int cnt, sx, sy, xmin, xmax, ymin, ymax;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_blob_tracker_if #(.VGA_WIDTH(AW), .VGA_HEIGHT(AH), .CH(2)) ba();
    vga_blob_tracker_if #(.VGA_WIDTH(BW), .VGA_HEIGHT(BH), .CH(2)) bb();

    vga_blob_tracker #(
        .VGA_WIDTH(AW), .VGA_HEIGHT(AH), .CH(2), .MIN_CNT(AMIN)
    ) dut_a (.clk(clk), .rst(rst), .bus(ba));

    vga_blob_tracker #(
        .VGA_WIDTH(BW), .VGA_HEIGHT(BH), .CH(2), .MIN_CNT(BMIN)
    ) dut_b (.clk(clk), .rst(rst), .bus(bb));

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     drops_a = 0;
    int     drops_b = 0;
    rec_t   qa[$];
    rec_t   qb[$];
    acc_t   ma[2];
    acc_t   mb[2];
    acc_t   mb1[2];
    logic [1:0] pat[AW*AH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ba.res_valid)
            qa.push_back('{int'(ba.res_ch), int'(ba.res_found),
                int'(ba.res_cnt), int'(ba.res_x), int'(ba.res_y),
                int'(ba.res_xmin), int'(ba.res_xmax),
                int'(ba.res_ymin), int'(ba.res_ymax), cyc});
        if (bb.res_valid)
            qb.push_back('{int'(bb.res_ch), int'(bb.res_found),
                int'(bb.res_cnt), int'(bb.res_x), int'(bb.res_y),
                int'(bb.res_xmin), int'(bb.res_xmax),
                int'(bb.res_ymin), int'(bb.res_ymax), cyc});
        if (ba.frame_drop) drops_a++;
        if (bb.frame_drop) drops_b++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic acc_t acc_clear(input int xw, input int yw);
        acc_t a;
        a = '{0, 0, 0, (1 << xw) - 1, 0, (1 << yw) - 1, 0};
        return a;
    endfunction

    function automatic acc_t acc_add(input acc_t a, input int x, input int y);
        acc_t r = a;
        r.cnt++;
        r.sx += x;
        r.sy += y;
        if (x < r.xmin) r.xmin = x;
        if (x > r.xmax) r.xmax = x;
        if (y < r.ymin) r.ymin = y;
        if (y > r.ymax) r.ymax = y;
        return r;
    endfunction

    // Expected record: rounded mean of the hit coordinates, or all-ones
    task automatic chk_rec(input string tag, input rec_t r, input acc_t m,
                           input int ch, input int minc,
                           input int xw, input int yw);
        int f, ex, ey;
        f  = (m.cnt > 0 && m.cnt >= minc) ? 1 : 0;
        ex = f ? (m.sx + m.cnt / 2) / m.cnt : (1 << xw) - 1;
        ey = f ? (m.sy + m.cnt / 2) / m.cnt : (1 << yw) - 1;
        chk({tag, ".ch"}, r.ch, ch);
        chk({tag, ".found"}, r.found, f);
        chk({tag, ".cnt"}, r.cnt, m.cnt);
        chk({tag, ".x"}, r.x, ex);
        chk({tag, ".y"}, r.y, ey);
        chk({tag, ".xmin"}, r.xmin, m.xmin);
        chk({tag, ".xmax"}, r.xmax, m.xmax);
        chk({tag, ".ymin"}, r.ymin, m.ymin);
        chk({tag, ".ymax"}, r.ymax, m.ymax);
    endtask

    task automatic a_drive(input logic fs, input logic pv, input logic [1:0] th);
        @(negedge clk);
        ba.frame_start = fs;
        ba.pix_valid   = pv;
        ba.thres       = th;
    endtask

    task automatic b_drive(input logic fs, input logic pv, input logic [1:0] th);
        @(negedge clk);
        bb.frame_start = fs;
        bb.pix_valid   = pv;
        bb.thres       = th;
    endtask

    task automatic rand_pat();
        int d0, d1;
        d0 = $urandom_range(0, 25);
        d1 = $urandom_range(0, 25);
        for (int i = 0; i < AW * AH; i++) begin
            pat[i][0] = ($urandom_range(0, 99) < d0);
            pat[i][1] = ($urandom_range(0, 99) < d1);
        end
    endtask

    // Full frame of pat[]; t_last is the cycle the last pixel was driven
    task automatic a_frame(input bit fs_first, input bit gaps,
                           output longint t_last);
        ma[0] = acc_clear(A_XW, A_YW);
        ma[1] = acc_clear(A_XW, A_YW);
        for (int i = 0; i < AW * AH; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) a_drive(1'b0, 1'b0, 2'b00);
            a_drive(fs_first && i == 0, 1'b1, pat[i]);
            for (int c = 0; c < 2; c++)
                if (pat[i][c]) ma[c] = acc_add(ma[c], i % AW, i / AW);
        end
        t_last = cyc;
        a_drive(1'b0, 1'b0, 2'b00);
    endtask

    task automatic b_frame(input bit fs_first);
        logic [1:0] th;
        mb[0] = acc_clear(B_XW, B_YW);
        mb[1] = acc_clear(B_XW, B_YW);
        for (int i = 0; i < BW * BH; i++) begin
            th = 2'($urandom_range(0, 3));
            b_drive(fs_first && i == 0, 1'b1, th);
            for (int c = 0; c < 2; c++)
                if (th[c]) mb[c] = acc_add(mb[c], i % BW, i / BW);
        end
    endtask

    task automatic wait_q(input bit is_b, input int n, input int budget);
        int k = 0;
        while ((is_b ? qb.size() : qa.size()) < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(is_b ? "wait_rec_b" : "wait_rec_a",
            (is_b ? qb.size() : qa.size()) >= n, 1);
    endtask

    // Collect and check both records of one A frame, including latency
    task automatic a_check_frame(input string tag, input longint t_last);
        rec_t r0, r1;
        wait_q(1'b0, 2, 2 * A_LAT + 20);
        if (qa.size() >= 2) begin
            r0 = qa.pop_front();
            r1 = qa.pop_front();
            chk({tag, ".lat0"}, r0.cyc - t_last, A_LAT);
            chk({tag, ".lat1"}, r1.cyc - r0.cyc, A_LAT);
            chk_rec({tag, ".c0"}, r0, ma[0], 0, AMIN, A_XW, A_YW);
            chk_rec({tag, ".c1"}, r1, ma[1], 1, AMIN, A_XW, A_YW);
        end
    endtask

    initial begin
        longint t;
        rec_t   r0, r1;
        ba.frame_start = 1'b0; ba.pix_valid = 1'b0; ba.thres = 2'b00;
        bb.frame_start = 1'b0; bb.pix_valid = 1'b0; bb.thres = 2'b00;

        repeat (3) @(negedge clk);
        chk("rst.valid", ba.res_valid, 0);
        chk("rst.busy", ba.busy, 0);
        chk("rst.drop", ba.frame_drop, 0);
        chk("rst.x", ba.res_x, (1 << A_XW) - 1);
        chk("rst.y", ba.res_y, (1 << A_YW) - 1);
        chk("rst.cnt", ba.res_cnt, 0);
        chk("rst.xmin", ba.res_xmin, 0);
        chk("rst.found", ba.res_found, 0);
        rst = 1'b0;

        // single pixel on ch0, below MIN_CNT; ch1 empty
        for (int i = 0; i < AW * AH; i++) pat[i] = 2'b00;
        pat[5 * AW + 10] = 2'b01;
        a_drive(1'b1, 1'b0, 2'b00);
        a_frame(1'b0, 1'b0, t);
        a_check_frame("single", t);

        // 4x4 block on ch0, three rounding hits on ch1 at x=1,2,2
        for (int i = 0; i < AW * AH; i++) pat[i] = 2'b00;
        for (int y = 3; y < 7; y++)
            for (int x = 10; x < 14; x++) pat[y * AW + x][0] = 1'b1;
        pat[1][1] = 1'b1;
        pat[2][1] = 1'b1;
        pat[AW + 2][1] = 1'b1;
        a_frame(1'b1, 1'b0, t);
        a_check_frame("block", t);

        for (int f = 0; f < 5; f++) begin
            rand_pat();
            if (f % 2 == 1) a_drive(1'b1, 1'b0, 2'b00);
            a_frame(f % 2 == 0, 1'b1, t);
            a_check_frame($sformatf("rand%0d", f), t);
        end

        // partial frame abandoned by frame_start
        a_drive(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 100; i++) a_drive(1'b0, 1'b1, 2'b11);
        repeat (5) a_drive(1'b0, 1'b0, 2'b00);
        chk("partial.noemit", qa.size(), 0);
        rand_pat();
        a_frame(1'b1, 1'b0, t);
        a_check_frame("after_partial", t);
        chk("partial.nodrop", drops_a, 0);

        // reset in DIV_Y of channel 0
        rand_pat();
        a_frame(1'b1, 1'b0, t);
        repeat (A_SW + 3) @(negedge clk);
        chk("mid.busy", ba.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.busy0", ba.busy, 0);
        chk("mid.valid", ba.res_valid, 0);
        chk("mid.x", ba.res_x, (1 << A_XW) - 1);
        chk("mid.y", ba.res_y, (1 << A_YW) - 1);
        chk("mid.cnt", ba.res_cnt, 0);
        chk("mid.xmax", ba.res_xmax, 0);
        repeat (2 * A_LAT + 10) @(negedge clk);
        chk("mid.noemit", qa.size(), 0);
        rand_pat();
        a_frame(1'b1, 1'b0, t);
        a_check_frame("after_rst", t);

        // overrun on the 4x2 instance: frame 2 ends while frame 1 divides
        b_frame(1'b1);
        mb1 = mb;
        b_frame(1'b0);
        b_drive(1'b0, 1'b0, 2'b00);
        wait_q(1'b1, 2, 100);
        chk("ovr.drops", drops_b, 1);
        if (qb.size() >= 2) begin
            r0 = qb.pop_front();
            r1 = qb.pop_front();
            chk_rec("ovr.f1c0", r0, mb1[0], 0, BMIN, B_XW, B_YW);
            chk_rec("ovr.f1c1", r1, mb1[1], 1, BMIN, B_XW, B_YW);
        end
        repeat (3) @(negedge clk);
        b_frame(1'b0);
        b_drive(1'b0, 1'b0, 2'b00);
        wait_q(1'b1, 2, 100);
        if (qb.size() >= 2) begin
            r0 = qb.pop_front();
            r1 = qb.pop_front();
            chk_rec("ovr.f3c0", r0, mb[0], 0, BMIN, B_XW, B_YW);
            chk_rec("ovr.f3c1", r1, mb[1], 1, BMIN, B_XW, B_YW);
        end
        chk("ovr.drops_end", drops_b, 1);

        repeat (10) @(negedge clk);
        chk("end.qa", qa.size(), 0);
        chk("end.qb", qb.size(), 0);
        chk("end.drops_a", drops_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
